branch_predictor_bht: RTL and testbench
=======================================

Name: branch_predictor_bht

Overview:
- Parametrised, tagged branch history table with per-entry saturating counters.
- Supplies `guess_taken` to the IF stage for the branch being fetched.
- Trains from the X stage, using the resolved branch outcome and the prediction originally made for that branch.
- Keeps saturating branch and mispredict event counters, exposed for CSR readout.

Parameters:
- PC_WIDTH, 32, width of PC inputs.
- LINES, 64, number of table entries; power of two, ≥2.
- CTR_WIDTH, 2, saturating counter width in bits; ≥1.
- HIST_BITS, 8, global history length; used only when the optional feature is enabled; ≤log2(LINES).
- STAT_WIDTH, 32, width of the event counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- guess_pc  in  PC_WIDTH  PC of the instruction in IF.
- guess_valid  in  1  the IF instruction is a conditional branch.
- guess_taken  out  1  predicted direction.
- guess_hist  out  HIST_BITS  history snapshot at lookup; the pipeline carries it to X.
- check_pc  in  PC_WIDTH  PC of the branch in X.
- check_valid  in  1  a conditional branch is resolving in X this cycle.
- check_taken  in  1  actual branch outcome.
- check_pred  in  1  prediction made for that branch at IF.
- check_hist  in  HIST_BITS  `guess_hist` value carried with that branch.
- stat_branches  out  STAT_WIDTH  count of resolved branches.
- stat_mispredicts  out  STAT_WIDTH  count of mispredicted branches.

Behaviour:
- Index and tag derivation
  - IB = log2(LINES).
  - Base index = `pc[IB+1:2]`.
  - Tag = `pc[PC_WIDTH-1:IB+2]`.
- Entry contents: valid bit, tag, CTR_WIDTH-bit counter.
- Reset (asynchronous, `rst_n` low)
  - All valid bits, counters, history and stat counters clear to 0.
  - `guess_taken` = 0, `guess_hist` = 0, both stats = 0.
  - Reset asserted mid-update discards that update.
- Lookup (combinational from registered state, zero latency)
  - Hit = entry valid and tag matches → `guess_taken` = counter MSB.
  - Miss, or `guess_valid` = 0 → `guess_taken` = 0.
- Update (registered; visible to lookups on the next rising edge), when `check_valid` = 1:
  - Hit, `check_taken` = 1: counter increments, saturating at 2^CTR_WIDTH−1.
  - Hit, `check_taken` = 0: counter decrements, saturating at 0.
  - Miss: entry allocated unconditionally (replaces the old tag); valid = 1; tag written.
    - Counter = 2^(CTR_WIDTH−1) (weak taken) if taken.
    - Counter = 2^(CTR_WIDTH−1)−1 (weak not-taken) if not taken.
    - For CTR_WIDTH = 1 these are 1 and 0.
- Simultaneous lookup and update to the same entry in one cycle
  - Lookup returns the pre-update value; no bypass.
- Statistics, when `check_valid` = 1:
  - `stat_branches` += 1.
  - `stat_mispredicts` += 1 if `check_pred` != `check_taken`.
  - Both saturate at all-ones; neither wraps.
- `check_valid` = 0: no state changes.
- X/Y inputs: none reach state when the corresponding `*_valid` is 0.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - A HIST_BITS global history register is maintained.
  - On each `check_valid`: `ghr <= {ghr[HIST_BITS-2:0], check_taken}`.
  - Lookup index = base index XOR zero-extended `ghr`.
  - Update index = base index XOR zero-extended `check_hist`.
  - `guess_hist` = `ghr`.
  - Tags are unchanged.
- Undefined:
  - No history register is built.
  - `guess_hist` is tied to 0 and `check_hist` is ignored.
  - Both lookup and update use the base index.

Test Plan:
- Reset, then `guess_pc`=0x0000_1000 with `guess_valid`=1 → `guess_taken`=0; both stats = 0.
- Miss update: `check_pc`=0x1000, `check_taken`=1, `check_pred`=0 → next cycle lookup of 0x1000 gives `guess_taken`=1 (counter 2'b10); `stat_branches`=1, `stat_mispredicts`=1.
- Saturation, same PC:
  - Three taken updates → counter 2'b11; one not-taken → 2'b10, prediction still 1.
  - A further two not-taken → 2'b00; a fourth not-taken holds at 0, prediction 0.
- Alias eviction (LINES=64): train 0x1000 taken, then update 0x1100 (same index, different tag) not-taken → lookup 0x1000 misses (0); lookup 0x1100 gives 0 (weak not-taken).
- Same-cycle lookup and update to one entry at counter 2'b01 with taken → that cycle shows 0; next cycle shows 1. Assert `rst_n` low mid-sequence → all outputs 0 immediately, without waiting for a clock edge.
- BP_GSHARE_EN defined, HIST_BITS=2:
  - Two taken updates → `guess_hist`=2'b11.
  - 0x1000 looks up index 0^3=3; an update with `check_hist`=3 writes entry 3, leaving entry 0 untouched.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// rtl/branch_predictor_bht.sv - tagged branch history table with saturating counters and event stats
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_bht #(
   parameter int PC_WIDTH   = 32,
   parameter int LINES      = 64,
   parameter int CTR_WIDTH  = 2,
   parameter int HIST_BITS  = 8,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PC_WIDTH-1:0]   guess_pc,
   input  logic                  guess_valid,
   output logic                  guess_taken,
   output logic [HIST_BITS-1:0]  guess_hist,
   input  logic [PC_WIDTH-1:0]   check_pc,
   input  logic                  check_valid,
   input  logic                  check_taken,
   input  logic                  check_pred,
   input  logic [HIST_BITS-1:0]  check_hist,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);
   localparam int IB    = $clog2(LINES);
   localparam int TAG_W = PC_WIDTH - IB - 2;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_WN  = CTR_WT - CTR_WIDTH'(1);

   logic                 valid_q [LINES];
   logic [TAG_W-1:0]     tag_q   [LINES];
   logic [CTR_WIDTH-1:0] ctr_q   [LINES];

   logic [IB-1:0]        look_off, upd_off;
   logic [IB-1:0]        gidx, uidx;
   logic [TAG_W-1:0]     gtag, utag;
   logic                 uhit;
   logic [CTR_WIDTH-1:0] ctr_cur, ctr_next;
   logic                 unused_ok;

`ifdef BP_GSHARE_EN
   logic [HIST_BITS-1:0] ghr;

   // History shifts in resolved outcomes, oldest bit falls off the top
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ghr <= '0;
      else if (check_valid)
         ghr <= HIST_BITS'({ghr, check_taken});
   end

   assign guess_hist = ghr;
   assign look_off   = IB'(ghr);
   assign upd_off    = IB'(check_hist);
   assign unused_ok  = ^{guess_pc[1:0], check_pc[1:0]};
`else
   assign guess_hist = '0;
   assign look_off   = '0;
   assign upd_off    = '0;
   assign unused_ok  = ^{check_hist, guess_pc[1:0], check_pc[1:0]};
`endif

   assign gidx = guess_pc[IB+1:2] ^ look_off;
   assign gtag = guess_pc[PC_WIDTH-1:IB+2];
   assign uidx = check_pc[IB+1:2] ^ upd_off;
   assign utag = check_pc[PC_WIDTH-1:IB+2];

   // Lookup reads registered state only, so a same-cycle update is not bypassed
   assign guess_taken = guess_valid && valid_q[gidx] && (tag_q[gidx] == gtag)
                        && ctr_q[gidx][CTR_WIDTH-1];

   assign uhit    = valid_q[uidx] && (tag_q[uidx] == utag);
   assign ctr_cur = ctr_q[uidx];

   always_comb begin
      ctr_next = check_taken ? CTR_WT : CTR_WN;
      if (uhit) begin
         if (check_taken)
            ctr_next = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_WIDTH'(1);
         else
            ctr_next = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            ctr_q[i]   <= '0;
         end
      end else if (check_valid) begin
         valid_q[uidx] <= 1'b1;
         tag_q[uidx]   <= utag;
         ctr_q[uidx]   <= ctr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (check_valid) begin
         if (stat_branches != '1)
            stat_branches <= stat_branches + STAT_WIDTH'(1);
         if ((check_pred != check_taken) && (stat_mispredicts != '1))
            stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb/tb_branch_predictor_bht.sv - directed self-checking bench for branch_predictor_bht
// Default build exercises the base-index table; BP_GSHARE_EN switches to the gshare scenario.
module tb_branch_predictor_bht;
   localparam int SW = 4;

   logic          clk;
   logic          rst_n;
   logic [31:0]   guess_pc;
   logic          guess_valid;
   logic          guess_taken;
   logic [1:0]    guess_hist;
   logic [31:0]   check_pc;
   logic          check_valid;
   logic          check_taken;
   logic          check_pred;
   logic [1:0]    check_hist;
   logic [SW-1:0] stat_branches;
   logic [SW-1:0] stat_mispredicts;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_br  = 0;
   int exp_mis = 0;

   branch_predictor_bht #(
      .PC_WIDTH(32), .LINES(64), .CTR_WIDTH(2), .HIST_BITS(2), .STAT_WIDTH(SW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .guess_pc(guess_pc), .guess_valid(guess_valid),
      .guess_taken(guess_taken), .guess_hist(guess_hist),
      .check_pc(check_pc), .check_valid(check_valid), .check_taken(check_taken),
      .check_pred(check_pred), .check_hist(check_hist),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at posedge+1; returns at posedge+1 of the next cycle
   task automatic do_update(input logic [31:0] pc, input logic tk, input logic pr,
                            input logic [1:0] h);
      check_pc = pc; check_taken = tk; check_pred = pr; check_hist = h;
      check_valid = 1'b1;
      @(posedge clk); #1;
      check_valid = 1'b0;
      if (exp_br < 15) exp_br++;
      if (pr != tk && exp_mis < 15) exp_mis++;
   endtask

   task automatic lookup(input logic [31:0] pc);
      guess_pc = pc; guess_valid = 1'b1;
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      guess_pc = '0; guess_valid = 1'b0;
      check_pc = '0; check_valid = 1'b0; check_taken = 1'b0; check_pred = 1'b0;
      check_hist = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_br = 0; exp_mis = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      lookup(32'h0000_1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL reset_guess: got %b expected 0", guess_taken); end
      n_tests++; if (guess_hist !== 2'b00) begin n_fail++; $display("FAIL reset_hist: got %b expected 00", guess_hist); end
      n_tests++; if (stat_branches !== 4'd0) begin n_fail++; $display("FAIL reset_branches: got %0d expected 0", stat_branches); end
      n_tests++; if (stat_mispredicts !== 4'd0) begin n_fail++; $display("FAIL reset_mispredicts: got %0d expected 0", stat_mispredicts); end
   endtask

   task automatic test_miss_alloc();
      do_update(32'h1000, 1'b1, 1'b0, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_weak_taken: got %b expected 1", guess_taken); end
      n_tests++; if (stat_branches !== 4'd1) begin n_fail++; $display("FAIL alloc_branches: got %0d expected 1", stat_branches); end
      n_tests++; if (stat_mispredicts !== 4'd1) begin n_fail++; $display("FAIL alloc_mispredicts: got %0d expected 1", stat_mispredicts); end
      guess_valid = 1'b0; #1;
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL guess_valid_low: got %b expected 0", guess_taken); end
   endtask

   task automatic test_saturation();
      repeat (3) do_update(32'h1000, 1'b1, 1'b1, 2'b00);
      do_update(32'h1000, 1'b0, 1'b1, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL sat_high_then_dec: got %b expected 1", guess_taken); end
      repeat (2) do_update(32'h1000, 1'b0, 1'b0, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL dec_to_zero: got %b expected 0", guess_taken); end
      do_update(32'h1000, 1'b0, 1'b0, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL sat_low_hold: got %b expected 0", guess_taken); end
      do_update(32'h1000, 1'b1, 1'b0, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL inc_from_zero: got %b expected 0", guess_taken); end
      do_update(32'h1000, 1'b1, 1'b1, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL inc_to_weak_taken: got %b expected 1", guess_taken); end
      n_tests++; if (stat_branches !== 4'(exp_br)) begin n_fail++; $display("FAIL sat_branches: got %0d expected %0d", stat_branches, exp_br); end
      n_tests++; if (stat_mispredicts !== 4'(exp_mis)) begin n_fail++; $display("FAIL sat_mispredicts: got %0d expected %0d", stat_mispredicts, exp_mis); end
   endtask

   task automatic test_alias();
      do_update(32'h1000, 1'b1, 1'b1, 2'b00);
      do_update(32'h1100, 1'b0, 1'b0, 2'b00);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL alias_evicted: got %b expected 0", guess_taken); end
      lookup(32'h1100);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL alias_weak_nt: got %b expected 0", guess_taken); end
      do_update(32'h1100, 1'b1, 1'b0, 2'b00);
      lookup(32'h1100);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL alias_train: got %b expected 1", guess_taken); end
   endtask

   task automatic test_same_cycle();
      do_update(32'h2004, 1'b0, 1'b0, 2'b00);
      guess_pc = 32'h2004; guess_valid = 1'b1;
      check_pc = 32'h2004; check_taken = 1'b1; check_pred = 1'b0; check_valid = 1'b1;
      #1;
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre: got %b expected 0", guess_taken); end
      @(posedge clk); #1;
      check_valid = 1'b0;
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL same_cycle_post: got %b expected 1", guess_taken); end
      check_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL async_rst_guess: got %b expected 0", guess_taken); end
      n_tests++; if (stat_branches !== 4'd0) begin n_fail++; $display("FAIL async_rst_branches: got %0d expected 0", stat_branches); end
      n_tests++; if (stat_mispredicts !== 4'd0) begin n_fail++; $display("FAIL async_rst_mispredicts: got %0d expected 0", stat_mispredicts); end
      @(posedge clk); #1;
      check_valid = 1'b0;
      rst_n = 1'b1;
      exp_br = 0; exp_mis = 0;
      lookup(32'h2004);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL rst_cleared_entry: got %b expected 0", guess_taken); end
   endtask

   task automatic test_idle();
      do_update(32'h1000, 1'b1, 1'b1, 2'b00);
      for (int i = 0; i < 5; i++) begin
         check_pc = 32'h1000; check_taken = 1'b0; check_pred = i[0];
         @(posedge clk); #1;
      end
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL idle_entry: got %b expected 1", guess_taken); end
      n_tests++; if (stat_branches !== 4'd1) begin n_fail++; $display("FAIL idle_branches: got %0d expected 1", stat_branches); end
      n_tests++; if (stat_mispredicts !== 4'd0) begin n_fail++; $display("FAIL idle_mispredicts: got %0d expected 0", stat_mispredicts); end
   endtask

   task automatic test_back_to_back();
      check_pc = 32'h3000; check_taken = 1'b1; check_pred = 1'b0; check_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check_pc = 32'h3000 + 32'(4 * (i % 4));
         check_pred = i[0];
         @(posedge clk); #1;
         if (exp_br < 15) exp_br++;
         if (!i[0] && exp_mis < 15) exp_mis++;
      end
      check_valid = 1'b0;
      n_tests++; if (stat_branches !== 4'(exp_br)) begin n_fail++; $display("FAIL b2b_branches_sat: got %0d expected %0d", stat_branches, exp_br); end
      n_tests++; if (stat_mispredicts !== 4'(exp_mis)) begin n_fail++; $display("FAIL b2b_mispredicts: got %0d expected %0d", stat_mispredicts, exp_mis); end
      lookup(32'h3008);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_entry: got %b expected 1", guess_taken); end
   endtask

   task automatic test_gshare();
      apply_reset();
      do_update(32'h1000, 1'b0, 1'b0, 2'b00);
      repeat (2) do_update(32'h1010, 1'b1, 1'b0, 2'b00);
      n_tests++; if (guess_hist !== 2'b11) begin n_fail++; $display("FAIL gs_hist_11: got %b expected 11", guess_hist); end
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL gs_idx3_miss: got %b expected 0", guess_taken); end
      do_update(32'h1000, 1'b1, 1'b0, 2'b11);
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b1) begin n_fail++; $display("FAIL gs_idx3_alloc: got %b expected 1", guess_taken); end
      repeat (2) do_update(32'h1010, 1'b0, 1'b0, 2'b00);
      n_tests++; if (guess_hist !== 2'b00) begin n_fail++; $display("FAIL gs_hist_00: got %b expected 00", guess_hist); end
      lookup(32'h1000);
      n_tests++; if (guess_taken !== 1'b0) begin n_fail++; $display("FAIL gs_idx0_untouched: got %b expected 0", guess_taken); end
   endtask

   initial begin
`ifdef BP_GSHARE_EN
      test_gshare();
`else
      test_reset();
      test_miss_alloc();
      test_saturation();
      test_alias();
      test_same_cycle();
      test_idle();
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
